// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// ex_stage_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the execute stage: bus widths, stall encoding,
// one-hot bit positions of the ALU / operand-select / mul-div fields,
// divider state encoding and the packed layouts of the ID->EX and EX->MEM
// pipeline buses.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

  // Bus widths
  localparam int ID_TO_EX_WD  = 167;
  localparam int EX_TO_MEM_WD = 76;
  localparam int STALL_W      = 6;

  // Stall vector encoding (one bit per pipeline register)
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int   STALL_EX  = 2;
  localparam int   STALL_MEM = 3;

  // alu_op one-hot positions (first listed operation is the MSB)
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  // sel_src1 one-hot positions
  localparam int SRC1_RS = 2;
  localparam int SRC1_PC = 1;
  localparam int SRC1_SA = 0;

  // sel_src2 one-hot positions
  localparam int SRC2_RT    = 3;
  localparam int SRC2_IMM_S = 2;
  localparam int SRC2_EIGHT = 1;
  localparam int SRC2_IMM_Z = 0;

  // md_op one-hot positions
  localparam int MD_DIV   = 7;
  localparam int MD_DIVU  = 6;
  localparam int MD_MULT  = 5;
  localparam int MD_MULTU = 4;
  localparam int MD_MFHI  = 3;
  localparam int MD_MFLO  = 2;
  localparam int MD_MTHI  = 1;
  localparam int MD_MTLO  = 0;

  // Divider FSM states
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // ID->EX bus layout, MSB first
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [7:0]  md_op;
  } id_ex_t;

  // EX->MEM bus layout, MSB first
  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

endpackage : ex_stage_pkg
`default_nettype wire

// File: rtl/ex_stage_div.sv
`default_nettype none
// ============================================================================
// div_unit
// ----------------------------------------------------------------------------
// Iterative 32-step restoring divider (one quotient bit per cycle) for the
// execute stage. Signed operation divides magnitudes and fixes signs at the
// output: quotient negated when operand signs differ, remainder follows the
// dividend. Divide by zero yields quotient all-ones, remainder = dividend
// (before sign fix-up) with unchanged latency.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           level: a division instruction sits in EX
//   signed_op       1 = div, 0 = divu
//   op_a, op_b      dividend, divisor (sampled when leaving IDLE)
//   ack             result consumed this edge; return to IDLE
//   busy, done      FSM status
//   quot, rem       sign-corrected results, valid while done
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [4:0]  count;
  logic [63:0] rq;          // {partial remainder, dividend/quotient}
  logic [31:0] divisor;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] partial;
  logic [32:0] diff;
  logic [63:0] rq_step;

  assign abs_a = (signed_op && op_a[31]) ? (32'd0 - op_a) : op_a;
  assign abs_b = (signed_op && op_b[31]) ? (32'd0 - op_b) : op_b;

  // Restoring step: the shifted partial remainder needs 33 bits because it
  // can reach 2*divisor-1.
  assign partial = rq[63:31];
  assign diff    = partial - {1'b0, divisor};
  assign rq_step = diff[32] ? {rq[62:0], 1'b0}
                            : {diff[31:0], rq[30:0], 1'b1};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; dropping start abandons any operation in progress
  always_comb begin
    next_state = state;
    case (state)
      DIV_IDLE: if (start) next_state = DIV_BUSY;
      DIV_BUSY: begin
        if (!start)               next_state = DIV_IDLE;
        else if (count == 5'd31)  next_state = DIV_DONE;
      end
      DIV_DONE: if (!start || ack) next_state = DIV_IDLE;
      default:  next_state = DIV_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == DIV_BUSY);
    done = (state == DIV_DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      rq      <= '0;
      divisor <= '0;
      count   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      rq      <= {32'd0, abs_a};
      divisor <= abs_b;
      count   <= '0;
      neg_q   <= signed_op & (op_a[31] ^ op_b[31]);
      neg_r   <= signed_op & op_a[31];
    end else if (state == DIV_BUSY) begin
      rq      <= rq_step;
      count   <= count + 5'd1;
    end
  end

  assign quot = neg_q ? (32'd0 - rq[31:0])  : rq[31:0];
  assign rem  = neg_r ? (32'd0 - rq[63:32]) : rq[63:32];

endmodule : div_unit
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// ex_stage
// ----------------------------------------------------------------------------
// Execute stage of the 5-stage in-order pipeline. Holds the ID->EX pipeline
// register, evaluates the ALU, drives the data SRAM request, owns HI/LO with
// a single-cycle multiplier and an iterative divider, and packs the EX->MEM
// bus plus the forwarding port back to ID.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               stall vector (bit 2 EX register, bit 3 MEM register)
//   id_to_ex_bus        instruction from ID
//   ex_to_mem_bus       {pc, ram_en, ram_wen, sel_rf_res, rf_we, waddr, result}
//   data_sram_*         data SRAM request (combinational from the register)
//   ex_if_write_data,
//   ex_reg_id,
//   ex_write_data       forwarding: rf_we, rf_waddr, ex_result
//   ex_is_load          EX holds a load (load-use detection in ID)
//   stallreq_for_ex     division in flight
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int ID_TO_EX_WD_P  = ID_TO_EX_WD,
  parameter int EX_TO_MEM_WD_P = EX_TO_MEM_WD,
  parameter int STALL_W_P      = STALL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W_P-1:0]      stall,
  input  logic [ID_TO_EX_WD_P-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD_P-1:0] ex_to_mem_bus,
  output logic                      data_sram_en,
  output logic [3:0]                data_sram_wen,
  output logic [31:0]               data_sram_addr,
  output logic [31:0]               data_sram_wdata,
  output logic                      ex_if_write_data,
  output logic [4:0]                ex_reg_id,
  output logic [31:0]               ex_write_data,
  output logic                      ex_is_load,
  output logic                      stallreq_for_ex
);

  id_ex_t      ex_reg;
  ex_mem_t     to_mem;

  logic        ex_advance;   // EX register accepts a new instruction this edge
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic [31:0] sa_z;
  logic [31:0] alu_res;
  logic [31:0] ex_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  logic        is_div;
  logic        div_done;
  logic        div_busy_unused;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        unused_bits;

  assign ex_advance = (stall[STALL_EX] == NO_STOP);

  // ID->EX pipeline register; a bubble is inserted when EX stops but MEM
  // keeps moving.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg <= '0;
    end else if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NO_STOP) begin
      ex_reg <= '0;
    end else if (ex_advance) begin
      ex_reg <= id_ex_t'(id_to_ex_bus);
    end
  end

  // Operand selection (one-hot AND-OR; a zero select yields zero)
  assign imm_s = {{16{ex_reg.inst[15]}}, ex_reg.inst[15:0]};
  assign imm_z = {16'd0, ex_reg.inst[15:0]};
  assign sa_z  = {27'd0, ex_reg.inst[10:6]};

  assign src1 = ({32{ex_reg.sel_src1[SRC1_RS]}} & ex_reg.rf_rdata1)
              | ({32{ex_reg.sel_src1[SRC1_PC]}} & ex_reg.pc)
              | ({32{ex_reg.sel_src1[SRC1_SA]}} & sa_z);

  assign src2 = ({32{ex_reg.sel_src2[SRC2_RT]}}    & ex_reg.rf_rdata2)
              | ({32{ex_reg.sel_src2[SRC2_IMM_S]}} & imm_s)
              | ({32{ex_reg.sel_src2[SRC2_EIGHT]}} & 32'd8)
              | ({32{ex_reg.sel_src2[SRC2_IMM_Z]}} & imm_z);

  // ALU
  always_comb begin
    logic [31:0] sra_res;
    sra_res = $signed(src2) >>> src1[4:0];
    alu_res = ({32{ex_reg.alu_op[ALU_ADD]}}  & (src1 + src2))
            | ({32{ex_reg.alu_op[ALU_SUB]}}  & (src1 - src2))
            | ({32{ex_reg.alu_op[ALU_SLT]}}  & {31'd0, ($signed(src1) < $signed(src2))})
            | ({32{ex_reg.alu_op[ALU_SLTU]}} & {31'd0, (src1 < src2)})
            | ({32{ex_reg.alu_op[ALU_AND]}}  & (src1 & src2))
            | ({32{ex_reg.alu_op[ALU_NOR]}}  & ~(src1 | src2))
            | ({32{ex_reg.alu_op[ALU_OR]}}   & (src1 | src2))
            | ({32{ex_reg.alu_op[ALU_XOR]}}  & (src1 ^ src2))
            | ({32{ex_reg.alu_op[ALU_SLL]}}  & (src2 << src1[4:0]))
            | ({32{ex_reg.alu_op[ALU_SRL]}}  & (src2 >> src1[4:0]))
            | ({32{ex_reg.alu_op[ALU_SRA]}}  & sra_res)
            | ({32{ex_reg.alu_op[ALU_LUI]}}  & {src2[15:0], 16'd0});
  end

  // Multiplier: the low 64 bits of a sign-extended product equal the signed
  // product, so both flavours use a plain 64x64 multiply.
  assign prod_s = {{32{ex_reg.rf_rdata1[31]}}, ex_reg.rf_rdata1}
                * {{32{ex_reg.rf_rdata2[31]}}, ex_reg.rf_rdata2};
  assign prod_u = {32'd0, ex_reg.rf_rdata1} * {32'd0, ex_reg.rf_rdata2};

  // Divider
  assign is_div = ex_reg.md_op[MD_DIV] | ex_reg.md_op[MD_DIVU];

  div_unit u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_op (ex_reg.md_op[MD_DIV]),
    .op_a      (ex_reg.rf_rdata1),
    .op_b      (ex_reg.rf_rdata2),
    .ack       (ex_advance),
    .busy      (div_busy_unused),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  assign stallreq_for_ex = is_div & ~div_done;

  // HI/LO are written on the edge the producer leaves EX, which is also the
  // edge a following mfhi/mflo enters, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (ex_advance) begin
      if (ex_reg.md_op[MD_MULT]) begin
        {hi, lo} <= prod_s;
      end else if (ex_reg.md_op[MD_MULTU]) begin
        {hi, lo} <= prod_u;
      end else if (is_div && div_done) begin
        hi <= div_rem;
        lo <= div_quot;
      end else begin
        if (ex_reg.md_op[MD_MTHI]) hi <= ex_reg.rf_rdata1;
        if (ex_reg.md_op[MD_MTLO]) lo <= ex_reg.rf_rdata1;
      end
    end
  end

  assign ex_result = ex_reg.md_op[MD_MFHI] ? hi
                   : ex_reg.md_op[MD_MFLO] ? lo
                   : alu_res;

  // Data SRAM request (word accesses only)
  assign data_sram_en    = ex_reg.data_ram_en;
  assign data_sram_wen   = ex_reg.data_ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = ex_reg.rf_rdata2;
  assign ex_is_load      = ex_reg.data_ram_en & ~|ex_reg.data_ram_wen;

  // Forwarding port
  assign ex_if_write_data = ex_reg.rf_we;
  assign ex_reg_id        = ex_reg.rf_waddr;
  assign ex_write_data    = ex_result;

  // EX->MEM bus
  always_comb begin
    to_mem              = '0;
    to_mem.pc           = ex_reg.pc;
    to_mem.data_ram_en  = ex_reg.data_ram_en;
    to_mem.data_ram_wen = ex_reg.data_ram_wen;
    to_mem.sel_rf_res   = ex_reg.sel_rf_res;
    to_mem.rf_we        = ex_reg.rf_we;
    to_mem.rf_waddr     = ex_reg.rf_waddr;
    to_mem.ex_result    = ex_result;
  end

  assign ex_to_mem_bus = to_mem;

  assign unused_bits = ^{ex_reg.inst[31:16], stall[1:0], stall[STALL_W_P-1:4],
                         div_busy_unused};

endmodule : ex_stage
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_ex_stage
// ----------------------------------------------------------------------------
// Directed self-checking bench for ex_stage. A simple stall controller turns
// stallreq_for_ex into a stall of the front end and EX; stall_force lets the
// sequence inject an EX bubble. Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  // One-hot encodings, written out independently of the design package
  localparam logic [11:0] A_ADD  = 12'b1000_0000_0000;
  localparam logic [11:0] A_SLTU = 12'b0001_0000_0000;
  localparam logic [11:0] A_SRA  = 12'b0000_0000_0010;
  localparam logic [2:0]  S1_RS  = 3'b100;
  localparam logic [2:0]  S1_PC  = 3'b010;
  localparam logic [2:0]  S1_SA  = 3'b001;
  localparam logic [3:0]  S2_RT  = 4'b1000;
  localparam logic [3:0]  S2_IMS = 4'b0100;
  localparam logic [3:0]  S2_8   = 4'b0010;
  localparam logic [7:0]  M_DIV   = 8'h80;
  localparam logic [7:0]  M_DIVU  = 8'h40;
  localparam logic [7:0]  M_MULT  = 8'h20;
  localparam logic [7:0]  M_MULTU = 8'h10;
  localparam logic [7:0]  M_MFHI  = 8'h08;
  localparam logic [7:0]  M_MFLO  = 8'h04;
  localparam logic [7:0]  M_MTLO  = 8'h01;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [5:0]   stall_force;
  logic [166:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_if_write_data;
  logic [4:0]   ex_reg_id;
  logic [31:0]  ex_write_data;
  logic         ex_is_load;
  logic         stallreq_for_ex;

  int compared   = 0;
  int mismatched = 0;

  ex_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .id_to_ex_bus     (id_to_ex_bus),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .ex_if_write_data (ex_if_write_data),
    .ex_reg_id        (ex_reg_id),
    .ex_write_data    (ex_write_data),
    .ex_is_load       (ex_is_load),
    .stallreq_for_ex  (stallreq_for_ex)
  );

  // EX stall request holds PC, IF, ID and EX; MEM receives bubbles.
  assign stall = stall_force | (stallreq_for_ex ? 6'b001111 : 6'b000000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [166:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] alu, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic en,
                                      input logic [3:0] wen, input logic we,
                                      input logic [4:0] wa, input logic [31:0] rd1,
                                      input logic [31:0] rd2, input logic [7:0] md);
    logic sel_res;
    sel_res = en & ~|wen;
    return {pc, inst, alu, s1, s2, en, wen, we, wa, sel_res, rd1, rd2, md};
  endfunction

  function automatic logic [166:0] md_inst(input logic [7:0] md, input logic [31:0] rd1,
                                           input logic [31:0] rd2);
    return mk(32'h0040_0000, 32'd0, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0,
              (md == M_MFHI || md == M_MFLO), 5'd9, rd1, rd2, md);
  endfunction

  // Counts cycles with the stall request high, bounded.
  task automatic wait_div(input string tag);
    int n;
    n = 0;
    while (stallreq_for_ex && n < 200) begin
      n++;
      tick();
    end
    check(tag, 76'(n), 76'd33);
  endtask

  initial begin
    rst          = 1'b1;
    stall_force  = 6'd0;
    id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

    // ---------------- reset ----------------
    tick();
    id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tick();
    check("rst_bus",      ex_to_mem_bus, 76'd0);
    check("rst_sram",     {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 76'd0);
    check("rst_fwd",      {ex_if_write_data, ex_reg_id, ex_write_data}, 76'd0);
    check("rst_ctl",      {ex_is_load, stallreq_for_ex}, 76'd0);

    rst = 1'b0;
    id_to_ex_bus = md_inst(M_MFHI, 32'd0, 32'd0);
    tick();
    check("rst_mfhi", ex_write_data, 76'd0);

    // ---------------- ALU ----------------
    id_to_ex_bus = mk(32'h0040_0010, 32'd0, A_ADD, S1_RS, S2_RT, 1'b0, 4'd0,
                      1'b1, 5'd4, 32'h7FFF_FFFF, 32'h0000_0001, 8'd0);
    tick();
    check("add_wrap_bus", ex_to_mem_bus,
          {32'h0040_0010, 1'b0, 4'd0, 1'b0, 1'b1, 5'd4, 32'h8000_0000});
    check("add_fwd", {ex_if_write_data, ex_reg_id, ex_write_data},
          {1'b1, 5'd4, 32'h8000_0000});

    id_to_ex_bus = mk(32'h0040_0014, 32'h0000_0103, A_SRA, S1_SA, S2_RT, 1'b0, 4'd0,
                      1'b1, 5'd5, 32'hFFFF_FFFF, 32'h8000_0000, 8'd0);
    tick();
    check("sra", ex_write_data, 76'hF800_0000);

    id_to_ex_bus = mk(32'h0040_0018, 32'd0, A_SLTU, S1_RS, S2_RT, 1'b0, 4'd0,
                      1'b1, 5'd6, 32'h0000_0001, 32'hFFFF_FFFF, 8'd0);
    tick();
    check("sltu", ex_write_data, 76'd1);

    id_to_ex_bus = mk(32'hBFC0_0000, 32'd0, A_ADD, S1_PC, S2_8, 1'b0, 4'd0,
                      1'b1, 5'd31, 32'd0, 32'd0, 8'd0);
    tick();
    check("pc_plus8", ex_write_data, 76'hBFC0_0008);

    // ---------------- loads / stores ----------------
    id_to_ex_bus = mk(32'h0040_0020, 32'h0000_FFFC, A_ADD, S1_RS, S2_IMS, 1'b1, 4'hF,
                      1'b0, 5'd0, 32'h0000_1000, 32'hDEAD_BEEF, 8'd0);
    tick();
    check("sw_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
          {1'b1, 4'hF, 32'h0000_0FFC, 32'hDEAD_BEEF});
    check("sw_not_load", ex_is_load, 76'd0);

    id_to_ex_bus = mk(32'h0040_0024, 32'h0000_FFFC, A_ADD, S1_RS, S2_IMS, 1'b1, 4'h0,
                      1'b1, 5'd8, 32'h0000_1000, 32'd0, 8'd0);
    tick();
    check("lw_load", {ex_is_load, data_sram_en, data_sram_wen, data_sram_addr},
          {1'b1, 1'b1, 4'h0, 32'h0000_0FFC});

    // ---------------- signed divide -7 / 2 ----------------
    id_to_ex_bus = md_inst(M_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    tick();
    id_to_ex_bus = md_inst(M_MFLO, 32'd0, 32'd0);
    wait_div("div_stall_cycles");
    tick();
    check("div_lo", ex_write_data, 76'hFFFF_FFFD);
    id_to_ex_bus = md_inst(M_MFHI, 32'd0, 32'd0);
    tick();
    check("div_hi", ex_write_data, 76'hFFFF_FFFF);

    // ---------------- divu by zero ----------------
    id_to_ex_bus = md_inst(M_DIVU, 32'd5, 32'd0);
    tick();
    id_to_ex_bus = md_inst(M_MFLO, 32'd0, 32'd0);
    wait_div("divu0_stall_cycles");
    tick();
    check("divu0_lo", ex_write_data, 76'hFFFF_FFFF);
    id_to_ex_bus = md_inst(M_MFHI, 32'd0, 32'd0);
    tick();
    check("divu0_hi", ex_write_data, 76'd5);

    // ---------------- multiply ----------------
    id_to_ex_bus = md_inst(M_MULT, 32'hFFFF_FFFF, 32'd2);
    tick();
    id_to_ex_bus = md_inst(M_MFHI, 32'd0, 32'd0);
    tick();
    check("mult_hi", ex_write_data, 76'hFFFF_FFFF);
    id_to_ex_bus = md_inst(M_MFLO, 32'd0, 32'd0);
    tick();
    check("mult_lo", ex_write_data, 76'hFFFF_FFFE);

    id_to_ex_bus = md_inst(M_MULTU, 32'hFFFF_FFFF, 32'd2);
    tick();
    id_to_ex_bus = md_inst(M_MFHI, 32'd0, 32'd0);
    tick();
    check("multu_hi", ex_write_data, 76'd1);
    id_to_ex_bus = md_inst(M_MFLO, 32'd0, 32'd0);
    tick();
    check("multu_lo", ex_write_data, 76'hFFFF_FFFE);

    // ---------------- reset mid-division ----------------
    id_to_ex_bus = md_inst(M_DIV, 32'd100, 32'd7);
    tick();
    id_to_ex_bus = md_inst(M_MFHI, 32'd0, 32'd0);
    for (int i = 0; i < 9; i++) tick();
    check("middiv_stalling", stallreq_for_ex, 76'd1);
    rst = 1'b1;
    tick();
    check("middiv_rst_drop", stallreq_for_ex, 76'd0);
    rst = 1'b0;
    tick();
    check("middiv_hi_zero", ex_write_data, 76'd0);
    id_to_ex_bus = md_inst(M_MFLO, 32'd0, 32'd0);
    tick();
    check("middiv_lo_zero", ex_write_data, 76'd0);

    // ---------------- bubble: mtlo squashed ----------------
    id_to_ex_bus = md_inst(M_MTLO, 32'h5A5A_5A5A, 32'd0);
    tick();
    stall_force  = 6'b000111;
    id_to_ex_bus = md_inst(M_MFLO, 32'd0, 32'd0);
    tick();
    check("bubble_bus", ex_to_mem_bus, 76'd0);
    check("bubble_stallreq", stallreq_for_ex, 76'd0);
    stall_force = 6'd0;
    tick();
    check("bubble_no_lo_write", ex_write_data, 76'd0);

    // mtlo allowed to leave EX does write LO
    id_to_ex_bus = md_inst(M_MTLO, 32'h5A5A_5A5A, 32'd0);
    tick();
    id_to_ex_bus = md_inst(M_MFLO, 32'd0, 32'd0);
    tick();
    check("mtlo_lo", ex_write_data, 76'h5A5A_5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_ex_stage
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage in-order pipeline, between ID and MEM.
- Holds the ID→EX pipeline register and evaluates the ALU.
- Drives the data SRAM request for loads and stores.
- Owns the HI/LO registers and an iterative 32-cycle divider; requests a pipeline stall while a division is in flight.
- Packs the EX→MEM bus and the EX forwarding port back to ID.

Parameters:
- ID_TO_EX_WD, 167, width of id_to_ex_bus (shared define).
- EX_TO_MEM_WD, 76, width of ex_to_mem_bus (shared define).
- STALL_W, 6, stall bus width (shared define StallBus).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset: synchronous, active-high.
- stall  in  6  pipeline stall vector; bit 2 = EX register, bit 3 = MEM register.
- id_to_ex_bus  in  167  bit order {pc[32], inst[32], alu_op[12], sel_src1[3], sel_src2[4], data_ram_en, data_ram_wen[4], rf_we, rf_waddr[5], sel_rf_res, rf_rdata1[32], rf_rdata2[32], md_op[8]}.
- ex_to_mem_bus  out  76  {pc[32], data_ram_en, data_ram_wen[4], sel_rf_res, rf_we, rf_waddr[5], ex_result[32]}.
- data_sram_en  out  1  data SRAM enable.
- data_sram_wen  out  4  byte write enables.
- data_sram_addr  out  32  data SRAM address (equals ALU result).
- data_sram_wdata  out  32  store data (rf_rdata2).
- ex_if_write_data / ex_reg_id / ex_write_data  out  1/5/32  forwarding port: rf_we, rf_waddr, ex_result.
- ex_is_load  out  1  data_ram_en & ~|data_ram_wen; used by ID for load-use detection.
- stallreq_for_ex  out  1  stall request to the stall controller.

Behaviour:
- Input register update on posedge, in priority order:
  - rst → zero.
  - stall[2]=Stop and stall[3]=NoStop → zero (bubble).
  - stall[2]=NoStop → load id_to_ex_bus.
  - otherwise hold.
- Zero register means every output is 0, stallreq_for_ex=0, no HI/LO write. This holds at reset and on bubbles.
- Operand select:
  - src1 (one-hot): rs, pc, zero-extended sa inst[10:6].
  - src2 (one-hot): rt, sign-extended imm, constant 8, zero-extended imm.
- alu_op (one-hot): add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Add/sub wrap modulo 2^32; no overflow trap.
  - Shifts use src1[4:0] as the amount, src2 as the value.
  - lui yields {imm,16'b0}.
- md_op (one-hot): div, divu, mult, multu, mfhi, mflo, mthi, mtlo.
- ex_result: hi if mfhi, lo if mflo, else ALU result.
- Data SRAM outputs are combinational from the register; only word stores are supported (wen passed through).
- mult/multu:
  - Single-cycle 64-bit product, signed or unsigned.
  - {hi,lo} written at the posedge where stall[2]=NoStop.
- mthi/mtlo write rf_rdata1 at that same edge. HI/LO reset to 0.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY when div/divu is present in the register. Latch |dividend|, |divisor| and the result signs; count=0.
  - BUSY: one restoring shift-subtract step per cycle. After 32 steps → DONE.
  - DONE: result valid; hold until stall[2]=NoStop, then → IDLE at the same edge HI/LO is written (hi=remainder, lo=quotient).
  - Signed results: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- stallreq_for_ex = div op in register and state≠DONE. A division therefore stalls for exactly 33 cycles; the instruction leaves EX on the 34th edge.
- Divide by zero: no trap. Quotient=0xFFFFFFFF and remainder=dividend (unsigned path, then the sign rules apply). Latency is unchanged.
- mfhi/mflo immediately after mult/div must see the new value: HI/LO are written at the edge the producer leaves EX, and the consumer enters EX at that same edge.
- rst mid-division → IDLE, count=0, HI/LO=0, no partial write.

Decomposition:
- Shared defines header holds:
  - ID_TO_EX_WD, EX_TO_MEM_WD, StallBus, Stop/NoStop.
  - alu_op and md_op bit indices.
- Sub-module div_unit (FSM + 64-bit shift register).
  - Interface: start, signed_op, op_a, op_b, busy, done, ack, quot, rem.
  - ex_stage instantiates it; the ALU, HI/LO and mult stay inline.

Test Plan:
- Reset held 2 cycles with random inputs → all outputs 0, stallreq_for_ex=0, then mfhi returns 0.
- add rs=0x7FFFFFFF + rt=1 → ex_result=0x80000000; sra 0x80000000 by 4 → 0xF8000000; sltu 1 vs 0xFFFFFFFF → 1.
- sw with rs=0x1000, imm=-4, rt=0xDEADBEEF → data_sram_en=1, wen=4'hF, addr=0xFFC, wdata=0xDEADBEEF; lw → ex_is_load=1, wen=0.
- div -7 / 2 → stallreq_for_ex high exactly 33 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; back-to-back mflo returns 0xFFFFFFFD.
- divu 5/0 → lo=0xFFFFFFFF, hi=5; mult 0xFFFFFFFF×2 signed → {hi,lo}=0xFFFFFFFF_FFFFFFFE; multu gives hi=1, lo=0xFFFFFFFE.
- rst asserted mid-division (cycle 10) → stallreq drops the next cycle, HI/LO=0; stall[2]=Stop with stall[3]=NoStop → ex_to_mem_bus=0 and no HI/LO write.
